// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: byte/half/word load-store initiator for a word-only data memory.
// Latency: load 2 cycles, word store 2, sub-word store 3 (read-modify-write), error 1.
// Backpressure: req_ready is high only in IDLE; the response is a one-cycle strobe
// with no backpressure.
// Optional: define LSU_ERR_CHECK_EN to flag misaligned or out-of-range requests.
// Without it, addresses are force-aligned and high address bits are ignored.
module lsu_mem_initiator #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_write_data,
  output logic              mem_we,
  input  logic [31:0]       mem_read_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t state, state_nxt;

  // Captured request fields used after the handshake
  logic [1:0]  r_size;
  logic        r_uns;
  logic [1:0]  r_off;
  logic [31:0] r_wdata;

  logic        accept;
  logic        req_err;
  logic [1:0]  req_off;

  assign accept = req_valid && req_ready;

`ifdef LSU_ERR_CHECK_EN
  logic misaligned;
  logic out_of_range;
  assign misaligned   = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
  assign out_of_range = |(req_addr >> (ADDR_W + 2));
  assign req_err      = misaligned || out_of_range;
`else
  // High address bits are deliberately ignored in this build
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_W+2];
  assign req_err        = 1'b0;
`endif

  // Byte offset of the addressed lane; half and word drop the low address bits,
  // which force-aligns them when error checking is off.
  always_comb begin
    req_off = 2'b00;
    case (req_size)
      2'b00:   req_off = req_addr[1:0];
      2'b01:   req_off = {req_addr[1], 1'b0};
      default: req_off = 2'b00;
    endcase
  end

  // Lane extraction and extension for loads
  logic [31:0] rd_shifted;
  logic [31:0] load_ext;
  assign rd_shifted = mem_read_data >> {r_off, 3'b000};

  always_comb begin
    load_ext = rd_shifted;
    case (r_size)
      2'b00:   load_ext = {{24{~r_uns & rd_shifted[7]}}, rd_shifted[7:0]};
      2'b01:   load_ext = {{16{~r_uns & rd_shifted[15]}}, rd_shifted[15:0]};
      default: load_ext = rd_shifted;
    endcase
  end

  // Lane merge for sub-word stores: only the addressed lane is replaced
  logic [31:0] lane_mask;
  logic [31:0] merge_mask;
  logic [31:0] merge_data;
  logic [31:0] merged;

  always_comb begin
    lane_mask = 32'hFFFF_FFFF;
    case (r_size)
      2'b00:   lane_mask = 32'h0000_00FF;
      2'b01:   lane_mask = 32'h0000_FFFF;
      default: lane_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign merge_mask = lane_mask << {r_off, 3'b000};
  assign merge_data = r_wdata << {r_off, 3'b000};
  assign merged     = (mem_read_data & ~merge_mask) | (merge_data & merge_mask);

  // Strobes decoded from state so reset removes them immediately
  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign mem_we    = (state == S_WRITE);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)              state_nxt = S_RESP;
          else if (!req_we)         state_nxt = S_LOAD;
          else if (req_size[1])     state_nxt = S_WRITE;
          else                      state_nxt = S_RMW_READ;
        end
      end
      S_LOAD:     state_nxt = S_RESP;
      S_RMW_READ: state_nxt = S_WRITE;
      S_WRITE:    state_nxt = S_RESP;
      S_RESP:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Request capture, memory-side registers and response data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_size         <= 2'b00;
      r_uns          <= 1'b0;
      r_off          <= 2'b00;
      r_wdata        <= 32'h0;
      mem_address    <= '0;
      mem_write_data <= 32'h0;
      rsp_rdata      <= 32'h0;
      rsp_err        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            r_size      <= req_size;
            r_uns       <= req_unsigned;
            r_off       <= req_off;
            r_wdata     <= req_wdata;
            mem_address <= req_addr[ADDR_W+1:2];
            rsp_rdata   <= 32'h0;
            rsp_err     <= req_err;
            if (req_we && req_size[1]) mem_write_data <= req_wdata;
          end
        end
        S_LOAD:     rsp_rdata      <= load_ext;
        S_RMW_READ: mem_write_data <= merged;
        default: ;
      endcase
    end
  end

endmodule
